shift_seq8: RTL

SHIFT_SEQ8 -- requirements
Module: shift_seq8

---
 rtl/shift_seq8.sv | 99 +++++++++
 1 files changed

// File: rtl/shift_seq8.sv
// Multi-cycle 8-bit shifter: the total shift is split into steps of at most
// 3 bits, one step per SHIFT cycle, with the result registered on DONE entry.

module shift_step (
  input  logic [1:0] op,
  input  logic [7:0] din,
  input  logic [1:0] amt,
  output logic [7:0] dout
);
  logic [3:0] back;

  // Rotate is the OR of a right shift and the complementary left shift.
  assign back = 4'd8 - {2'b00, amt};

  always_comb begin
    dout = din;
    case (op)
      2'b00:   dout = din >> amt;
      2'b01:   dout = din << amt;
      2'b10:   dout = $signed(din) >>> amt;
      default: dout = (din >> amt) | (din << back);
    endcase
  end
endmodule

module shift_seq8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] d_in,
  input  logic [2:0] shamt,
  output logic       busy,
  output logic       done,
  output logic [7:0] d_out
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t     state, state_nxt;
  logic [7:0] acc, acc_sh;
  logic [2:0] rem, rem_nxt;
  logic [1:0] op_r, step;

  assign step    = (rem > 3'd3) ? 2'd3 : rem[1:0];
  assign rem_nxt = rem - {1'b0, step};

  shift_step u_step (
    .op  (op_r),
    .din (acc),
    .amt (step),
    .dout(acc_sh)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = (shamt == 3'd0) ? DONE : SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (rem_nxt == 3'd0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= 8'h00;
      rem   <= 3'd0;
      op_r  <= 2'b00;
      d_out <= 8'h00;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          acc  <= d_in;
          rem  <= shamt;
          op_r <= op;
          // Zero-length shift skips SHIFT, so DONE entry happens here.
          if (shamt == 3'd0) d_out <= d_in;
        end
        SHIFT: begin
          acc <= acc_sh;
          rem <= rem_nxt;
          if (rem_nxt == 3'd0) d_out <= acc_sh;
        end
        default: ;
      endcase
    end
  end
endmodule
